mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares one 4-input `multiplexer4to1` datapath resource between four requesters. It owns the mux `selector`, grants exactly one requester at a time, and holds the grant until the owner signals completion, drops its request, or exceeds a hold-time limit. It sits between the requesting units and the shared mux, for example a shared memory or writeback port.

## Interface
- `TIMEOUT`, default 16: maximum consecutive cycles one owner may hold the grant; legal range 2..256.
- `CNT_W`, default `$clog2(TIMEOUT)`: width of the hold counter; derived, never overridden.

- `clk` input 1: rising-edge clock.
- `reset` input 1: **one clock; reset is asynchronous and active-low**.
- `req` input 4: request per requester; the requester holds it high until it is served.
- `done` input 1: one-cycle pulse from the resource; the current transfer is complete.
- `grant` output 4: one-hot grant, or zero when idle.
- `selector` output 2: drives `multiplexer4to1.selector`; the index of the current or last owner.
- `valid` output 1: high while a grant is active; equals `|grant`.
- `timeout` output 1: one-cycle pulse; the last grant was force-released.

## Operation
- State machine with 2 states, IDLE and GRANT.
- Priority pointer `ptr` (2 bits) resets to 0.
- **IDLE**
  - If `req != 0`, pick the first set bit scanning `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - Load `owner`, `grant = 1<<owner`, `selector = owner`, `cnt = 0`, and go to GRANT.
  - If `req == 0`, stay in IDLE. `grant` and `valid` stay 0, and `selector` holds its last value.
- **GRANT**
  - A release condition occurs on a cycle where any of these holds: `done`, `!req[owner]`, or `cnt == TIMEOUT-1`.
  - On release, go to IDLE, clear `grant`, and set `ptr = owner+1` (mod 4).
  - Otherwise, `cnt <= cnt+1`.
- `timeout` pulses in the first IDLE cycle after a release that was caused only by `cnt == TIMEOUT-1`.
  - If `done` or a request drop coincides with the limit, the release is normal and `timeout` stays 0.
- A released owner gets lowest priority on the next arbitration.
- No requester waits more than 3 × (TIMEOUT+1) cycles.
- `req` bits of non-owners are ignored during GRANT.
- `done` is ignored in IDLE.
- Counter arithmetic is unsigned, `CNT_W` bits. It never wraps, because release occurs at `TIMEOUT-1`.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator) clears everything immediately, mid-transfer included:
  - state = IDLE
  - `grant` = 0, `selector` = 0, `valid` = 0, `timeout` = 0
  - `ptr` = 0, `cnt` = 0
- Request-to-grant latency:
  - `req` sampled high at edge N gives `grant` valid after edge N, when the arbiter is in IDLE.
  - Best case is 1 cycle.
- Release latency:
  - A release condition sampled at edge M drops `grant` after edge M.
  - The next grant follows after edge M+1.
  - Every hand-over therefore has exactly one dead cycle, with `selector` stable at the old owner, so the mux output settles.
- Maximum grant length is TIMEOUT cycles, counting the cycles where `grant` is high.
- All outputs are registered. There is no combinational path from `req` or `done` to any output.

## Structure
- Shared package `mux_arb_pkg`:
  - state enum `{ARB_IDLE, ARB_GRANT}`
  - `ARB_NREQ = 4`, `ARB_SEL_W = 2`
- Sub-module `rr_pick4`:
  - Purely combinational.
  - Inputs `req[3:0]`, `ptr[1:0]`.
  - Outputs `any`, `idx[1:0]`.
  - Implements the rotate, priority-encode and unrotate steps.
- Top level holds the state register, `ptr`, `owner`, `cnt`, and the output registers.

## Test plan
- Reset then single request:
  - Stimulus: `req=4'b0100` from cycle 1, `done` pulse at cycle 5.
  - Required: `grant=4'b0100` and `selector=2` from cycle 2 through the cycle containing the `done` edge; `grant=0` afterwards; `timeout` stays 0.
- Round-robin fairness:
  - Stimulus: `req=4'b1111` held, `done` pulsed 2 cycles into each grant.
  - Required: owners in order 0, 1, 2, 3, 0; one idle cycle between grants.
- Timeout:
  - Stimulus: `TIMEOUT=4`, `req=4'b0010` held, no `done`.
  - Required: `grant` high for exactly 4 cycles; `timeout` pulses once in the next cycle; the requester is re-granted after that idle cycle.
- Simultaneous events:
  - Stimulus: `done` asserted on the cycle where `cnt == TIMEOUT-1`.
  - Required: normal release with `timeout=0`; `ptr` advances.
- Request drop and pointer rotation:
  - Stimulus: owner 3 drops `req` mid-grant while `req=4'b1001` is pending.
  - Required: release; next grant goes to 0 (`ptr` wrapped from 3 to 0).
- Reset mid-operation:
  - Stimulus: assert `reset` low asynchronously during GRANT with owner 2.
  - Required: `grant=0`, `selector=0`, `valid=0` immediately without a clock edge; after release, `req=4'b0110` grants 1 first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (idle / grant held)
//   ARB_NREQ    : number of requesters sharing the multiplexer
//   ARB_SEL_W   : width of the multiplexer selector / requester index
package mux_arb_pkg;

    localparam int ARB_NREQ  = 4;
    localparam int ARB_SEL_W = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Ports:
//   req [3:0] : request vector
//   ptr [1:0] : index holding highest priority
//   any       : at least one request is set
//   idx [1:0] : first set request found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [ARB_NREQ-1:0]  req,
    input  logic [ARB_SEL_W-1:0] ptr,
    output logic                 any,
    output logic [ARB_SEL_W-1:0] idx
);

    logic [ARB_NREQ-1:0]  rot;
    logic [ARB_SEL_W-1:0] off;
    logic                 hit;

    always_comb begin
        rot = '0;
        off = '0;
        hit = 1'b0;
        // rot[0] is the requester at ptr; the 2-bit index sum wraps mod 4
        for (int unsigned i = 0; i < ARB_NREQ; i++) begin
            rot[i] = req[ARB_SEL_W'(i) + ptr];
        end
        for (int unsigned i = 0; i < ARB_NREQ; i++) begin
            if (rot[i] && !hit) begin
                off = ARB_SEL_W'(i);
                hit = 1'b1;
            end
        end
        any = |req;
        idx = off + ptr;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the selector of a shared 4-input multiplexer.
// One requester is granted at a time; the grant is held until done, the
// owner drops its request, or TIMEOUT consecutive grant cycles elapse.
// Parameters:
//   TIMEOUT : maximum grant length in cycles (2..256)
//   CNT_W   : hold counter width, derived from TIMEOUT
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   req      : per-requester request, held until served
//   done     : one-cycle completion pulse from the shared resource
//   grant    : one-hot grant, zero when idle
//   selector : multiplexer select, index of current or last owner
//   valid    : grant active (|grant)
//   timeout  : one-cycle pulse after a forced release at the hold limit
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ARB_NREQ-1:0]  req,
    input  logic                 done,
    output logic [ARB_NREQ-1:0]  grant,
    output logic [ARB_SEL_W-1:0] selector,
    output logic                 valid,
    output logic                 timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_t           state, state_n;
    logic [ARB_SEL_W-1:0] ptr, ptr_n;
    logic [ARB_SEL_W-1:0] owner, owner_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [ARB_NREQ-1:0]  grant_n;
    logic [ARB_SEL_W-1:0] selector_n;
    logic                 valid_n;
    logic                 timeout_n;

    logic                 pick_any;
    logic [ARB_SEL_W-1:0] pick_idx;
    logic                 at_limit;
    logic                 release_now;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        cnt_n       = cnt;
        grant_n     = grant;
        selector_n  = selector;
        valid_n     = valid;
        timeout_n   = 1'b0;
        at_limit    = (cnt == CNT_MAX);
        release_now = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    owner_n    = pick_idx;
                    grant_n    = ARB_NREQ'(1) << pick_idx;
                    selector_n = pick_idx;
                    valid_n    = 1'b1;
                    cnt_n      = '0;
                    state_n    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                release_now = done || !req[owner] || at_limit;
                if (release_now) begin
                    state_n   = ARB_IDLE;
                    grant_n   = '0;
                    valid_n   = 1'b0;
                    ptr_n     = owner + 1'b1;
                    // only a release caused solely by the hold limit is a timeout
                    timeout_n = at_limit && !done && req[owner];
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            grant    <= '0;
            selector <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            cnt      <= cnt_n;
            grant    <= grant_n;
            selector <= selector_n;
            valid    <= valid_n;
            timeout  <= timeout_n;
        end
    end

endmodule
